// File: rtl/p405s_srm_msk_enc.sv
// Rotate-mask encoder: turns a 32-bit MSB-first mask into MB/ME fields by scanning
// BITS_PER_CYC bits per cycle. Optional self-check state enabled by P405_SRM_MSKENC_SELFCHK_EN.
module p405s_srm_msk_enc #(
  parameter int BITS_PER_CYC = 8
) (
  input  logic        CB,
  input  logic        resetCore,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [0:31] reqMask,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [0:4]  mbField,
  output logic [0:4]  meField,
  output logic        maskValid,
  output logic        zeroMask,
  output logic        encErr,
  output logic [1:0]  dbgState
);

  localparam int NCHUNK = 32 / BITS_PER_CYC;

  generate
    if (BITS_PER_CYC != 1 && BITS_PER_CYC != 2 && BITS_PER_CYC != 4 &&
        BITS_PER_CYC != 8 && BITS_PER_CYC != 16 && BITS_PER_CYC != 32) begin : g_bad_bpc
      $error("BITS_PER_CYC must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Handshake: a request transfers on a rising CB edge where reqValid && reqReady;
  // a response transfers on a rising edge where rspValid && rspReady. rspValid and
  // all result fields stay stable from assertion until that transfer.

  state_t      state_q, state_d;
  logic [0:31] mask_q, mask_d;
  logic [5:0]  chunk_q, chunk_d;
  logic [1:0]  rise_q, rise_d;
  logic [4:0]  mb_q, mb_d;
  logic [4:0]  me_q, me_d;
  logic [4:0]  mb_out_q, mb_out_d;
  logic [4:0]  me_out_q, me_out_d;
  logic        mvalid_q, mvalid_d;
  logic        zero_q, zero_d;

  logic [1:0]  scan_rise;
  logic [4:0]  scan_mb, scan_me;
  logic [4:0]  bit_idx, pred_idx, succ_idx;
  logic        last_chunk;
  logic [4:0]  res_mb, res_me;
  logic        res_valid, res_zero;

  // Examine this cycle's chunk; captures and rise count are folded onto the
  // running values so the final chunk's edges are visible to the result logic.
  always_comb begin
    scan_rise = rise_q;
    scan_mb   = mb_q;
    scan_me   = me_q;
    bit_idx   = '0;
    pred_idx  = '0;
    succ_idx  = '0;
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      bit_idx  = 5'(int'(chunk_q) * BITS_PER_CYC + j);
      pred_idx = bit_idx - 5'd1;
      succ_idx = bit_idx + 5'd1;
      if (mask_q[bit_idx] && !mask_q[pred_idx]) begin
        scan_mb = bit_idx;
        if (scan_rise != 2'd2) scan_rise = scan_rise + 2'd1;
      end
      if (mask_q[bit_idx] && !mask_q[succ_idx]) scan_me = bit_idx;
    end
  end

  assign last_chunk = (chunk_q == 6'(NCHUNK - 1));

  // All-ones and all-zeros have no rise at all, so they are classified first.
  always_comb begin
    res_mb    = '0;
    res_me    = '0;
    res_valid = 1'b0;
    res_zero  = 1'b0;
    if (&mask_q) begin
      res_valid = 1'b1;
      res_me    = 5'd31;
    end else if (mask_q == '0) begin
      res_zero = 1'b1;
    end else if (scan_rise == 2'd1) begin
      res_valid = 1'b1;
      res_mb    = scan_mb;
      res_me    = scan_me;
    end
  end

`ifdef P405_SRM_MSKENC_SELFCHK_EN
  logic [0:31] regen;
  logic        chk_err;
  logic        err_q, err_d;

  // Rebuild the mask the way the decoder would and compare with the original.
  always_comb begin
    regen = '0;
    for (int i = 0; i < 32; i++) begin
      if (mb_out_q <= me_out_q) regen[i] = (5'(i) >= mb_out_q) && (5'(i) <= me_out_q);
      else                      regen[i] = (5'(i) >= mb_out_q) || (5'(i) <= me_out_q);
    end
  end
  assign chk_err = mvalid_q && !zero_q && (regen != mask_q);
  assign encErr  = err_q;
`else
  assign encErr = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    chunk_d  = chunk_q;
    rise_d   = rise_q;
    mb_d     = mb_q;
    me_d     = me_q;
    mb_out_d = mb_out_q;
    me_out_d = me_out_q;
    mvalid_d = mvalid_q;
    zero_d   = zero_q;
`ifdef P405_SRM_MSKENC_SELFCHK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          mask_d  = reqMask;
          chunk_d = '0;
          rise_d  = '0;
          mb_d    = '0;
          me_d    = '0;
`ifdef P405_SRM_MSKENC_SELFCHK_EN
          err_d   = 1'b0;
`endif
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        chunk_d = chunk_q + 6'd1;
        rise_d  = scan_rise;
        mb_d    = scan_mb;
        me_d    = scan_me;
        if (last_chunk) begin
          mb_out_d = res_mb;
          me_out_d = res_me;
          mvalid_d = res_valid;
          zero_d   = res_zero;
`ifdef P405_SRM_MSKENC_SELFCHK_EN
          state_d  = S_CHECK;
`else
          state_d  = S_DONE;
`endif
        end
      end
      S_CHECK: begin
`ifdef P405_SRM_MSKENC_SELFCHK_EN
        err_d = chk_err;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rspReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CB) begin
    if (resetCore) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      chunk_q  <= '0;
      rise_q   <= '0;
      mb_q     <= '0;
      me_q     <= '0;
      mb_out_q <= '0;
      me_out_q <= '0;
      mvalid_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef P405_SRM_MSKENC_SELFCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      chunk_q  <= chunk_d;
      rise_q   <= rise_d;
      mb_q     <= mb_d;
      me_q     <= me_d;
      mb_out_q <= mb_out_d;
      me_out_q <= me_out_d;
      mvalid_q <= mvalid_d;
      zero_q   <= zero_d;
`ifdef P405_SRM_MSKENC_SELFCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign reqReady  = (state_q == S_IDLE);
  assign rspValid  = (state_q == S_DONE);
  assign mbField   = mb_out_q;
  assign meField   = me_out_q;
  assign maskValid = mvalid_q;
  assign zeroMask  = zero_q;
  assign dbgState  = state_q;

endmodule

// File: tb/tb_p405s_srm_msk_enc.sv
// Directed bench for p405s_srm_msk_enc: field encoding, latency, backpressure and
// mid-scan reset. Honours P405_SRM_MSKENC_SELFCHK_EN for the expected latency.
module tb_p405s_srm_msk_enc;
  parameter int BPC = 8;
`ifdef P405_SRM_MSKENC_SELFCHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  // Edges from the accepting edge up to the first edge that samples rspValid high.
  localparam int EXP_LAT = 32 / BPC + 1 + CHK;
  localparam int W = 13;

  logic        CB;
  logic        resetCore;
  logic        reqValid;
  logic        reqReady;
  logic [0:31] reqMask;
  logic        rspValid;
  logic        rspReady;
  logic [0:4]  mbField;
  logic [0:4]  meField;
  logic        maskValid;
  logic        zeroMask;
  logic        encErr;
  logic [1:0]  dbgState;

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  p405s_srm_msk_enc #(.BITS_PER_CYC(BPC)) dut (
    .CB(CB), .resetCore(resetCore), .reqValid(reqValid), .reqReady(reqReady),
    .reqMask(reqMask), .rspValid(rspValid), .rspReady(rspReady),
    .mbField(mbField), .meField(meField), .maskValid(maskValid),
    .zeroMask(zeroMask), .encErr(encErr), .dbgState(dbgState)
  );

  // clock / reset
  initial CB = 1'b0;
  always #5 CB = ~CB;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [4:0] mb, input logic [4:0] me,
                                            input logic mv, input logic zm);
    return {mb, me, mv, zm, 1'b0};
  endfunction

  function automatic logic [W-1:0] observed();
    return {mbField, meField, maskValid, zeroMask, encErr};
  endfunction

  // driver: call at a negedge; returns at the negedge after the accepting edge
  task automatic send_req(input logic [31:0] m, input logic [W-1:0] e);
    check_eq("req_ready_idle", 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqMask  = m;
    exp_q.push_back(e);
    @(posedge CB);
    @(negedge CB);
    reqValid = 1'b0;
  endtask

  task automatic wait_check_rsp(input string tag);
    int n;
    logic [W-1:0] e;
    n = 1;
    while (!rspValid && n < 200) begin
      @(negedge CB);
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(EXP_LAT));
    check_eq({tag, "_rdy"}, 32'(reqReady), 32'd0);
    e = exp_q.pop_front();
    check_eq({tag, "_fields"}, 32'(observed()), 32'(e));
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge CB);
    check_eq({tag, "_drop"}, 32'(rspValid), 32'd0);
    check_eq({tag, "_idle"}, 32'(reqReady), 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] m, input logic [W-1:0] e);
    send_req(m, e);
    wait_check_rsp(tag);
    finish_rsp(tag);
  endtask

  initial begin
    logic [W-1:0] held;
    n_checks  = 0;
    n_errors  = 0;
    resetCore = 1'b1;
    reqValid  = 1'b0;
    reqMask   = '0;
    rspReady  = 1'b1;
    repeat (3) @(posedge CB);
    @(negedge CB);
    check_eq("rst_req_ready", 32'(reqReady), 32'd1);
    check_eq("rst_rsp_valid", 32'(rspValid), 32'd0);
    check_eq("rst_fields",    32'(observed()), 32'd0);
    resetCore = 1'b0;
    @(negedge CB);

    run_vec("run_8_15",   32'h00FF0000, pack_exp(5'd8,  5'd15, 1'b1, 1'b0));
    run_vec("wrap_28_3",  32'hF000000F, pack_exp(5'd28, 5'd3,  1'b1, 1'b0));
    run_vec("lsb_only",   32'h00000001, pack_exp(5'd31, 5'd31, 1'b1, 1'b0));
    run_vec("all_ones",   32'hFFFFFFFF, pack_exp(5'd0,  5'd31, 1'b1, 1'b0));
    run_vec("all_zeros",  32'h00000000, pack_exp(5'd0,  5'd0,  1'b0, 1'b1));
    run_vec("two_runs",   32'h0F0F0000, pack_exp(5'd0,  5'd0,  1'b0, 1'b0));
    run_vec("msb_only",   32'h80000000, pack_exp(5'd0,  5'd0,  1'b1, 1'b0));
    run_vec("wrap_31_0",  32'h80000001, pack_exp(5'd31, 5'd0,  1'b1, 1'b0));
    run_vec("run_1_30",   32'h7FFFFFFE, pack_exp(5'd1,  5'd30, 1'b1, 1'b0));
    run_vec("run_0_15",   32'hFFFF0000, pack_exp(5'd0,  5'd15, 1'b1, 1'b0));
    run_vec("split_ends", 32'h80000002, pack_exp(5'd0,  5'd0,  1'b0, 1'b0));
    run_vec("wrap_24_7",  32'hFF0000FF, pack_exp(5'd24, 5'd7,  1'b1, 1'b0));

    // backpressure: response held, second request ignored until handshake
    rspReady = 1'b0;
    send_req(32'h0000FFFF, pack_exp(5'd16, 5'd31, 1'b1, 1'b0));
    wait_check_rsp("bp_first");
    held     = observed();
    reqValid = 1'b1;
    reqMask  = 32'h80000001;
    for (int c = 0; c < 10; c++) begin
      @(negedge CB);
      check_eq("bp_hold_valid",  32'(rspValid), 32'd1);
      check_eq("bp_hold_fields", 32'(observed()), 32'(held));
      check_eq("bp_hold_rdy",    32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(negedge CB);
    check_eq("bp_drop",  32'(rspValid), 32'd0);
    check_eq("bp_idle",  32'(reqReady), 32'd1);
    exp_q.push_back(pack_exp(5'd31, 5'd0, 1'b1, 1'b0));
    @(posedge CB);
    @(negedge CB);
    reqValid = 1'b0;
    wait_check_rsp("bp_second");
    finish_rsp("bp_second");

    // reset during the second scan cycle drops the pending response
    reqValid = 1'b1;
    reqMask  = 32'h00FF0000;
    @(posedge CB);
    @(negedge CB);
    reqValid = 1'b0;
    @(posedge CB);
    @(negedge CB);
    resetCore = 1'b1;
    @(posedge CB);
    @(negedge CB);
    check_eq("mid_rst_valid",  32'(rspValid), 32'd0);
    check_eq("mid_rst_ready",  32'(reqReady), 32'd1);
    check_eq("mid_rst_fields", 32'(observed()), 32'd0);
    resetCore = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CB);
      check_eq("mid_rst_no_rsp", 32'(rspValid), 32'd0);
    end
    run_vec("post_rst", 32'h00F00000, pack_exp(5'd8, 5'd11, 1'b1, 1'b0));

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
